// File: rtl/clk_div_pkg.sv
// Shared constants, channel state and divisor clamp for the multi-channel clock-enable divider.
// Used by both build variants (CLKDIV_SYNC_EN defined or not).
package clk_div_pkg;

    localparam int unsigned DIV_MIN   = 2;
    localparam int unsigned DIV_W_MAX = 32;

    // Channel state is held at the widest supported divisor; unused upper bits stay zero.
    typedef struct packed {
        logic [DIV_W_MAX-1:0] cnt;
        logic [DIV_W_MAX-1:0] div_act;
    } ch_state_t;

    function automatic logic [DIV_W_MAX-1:0] clamp_div(input logic [DIV_W_MAX-1:0] v);
        return (v < DIV_W_MAX'(DIV_MIN)) ? DIV_W_MAX'(DIV_MIN) : v;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Control/status bundle of clk_div_multi; sync_req exists only when CLKDIV_SYNC_EN is defined.
interface clk_div_multi_if #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned DIV_W = 16
);

    logic [NCH-1:0]       ch_en;
    logic [NCH*DIV_W-1:0] div_val;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       clk_out;
    logic [NCH*DIV_W-1:0] div_act;

`ifdef CLKDIV_SYNC_EN
    logic sync_req;

    modport master (output ch_en, div_val, sync_req, input tick, clk_out, div_act);
    modport slave  (input ch_en, div_val, sync_req, output tick, clk_out, div_act);
`else
    modport master (output ch_en, div_val, input tick, clk_out, div_act);
    modport slave  (input ch_en, div_val, output tick, clk_out, div_act);
`endif

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: wrap counter, glitch-free divisor latch, registered tick and divided level.
// The sync input exists only when CLKDIV_SYNC_EN is defined.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned DIV_RST = 1000
) (
    input  logic             clk,
    input  logic             rst,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync,
`endif
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    output logic             tick,
    output logic             clk_out,
    output logic [DIV_W-1:0] div_act
);

    ch_state_t            st;
    logic [DIV_W_MAX-1:0] d;
    logic [DIV_W_MAX-1:0] last;
    logic                 realign;

    assign d       = clamp_div(st.div_act);
    assign last    = d - DIV_W_MAX'(1);
    assign div_act = st.div_act[DIV_W-1:0];

`ifdef CLKDIV_SYNC_EN
    assign realign = sync;
`else
    assign realign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            st.cnt     <= '0;
            st.div_act <= DIV_W_MAX'(DIV_RST);
            tick       <= 1'b0;
            clk_out    <= 1'b0;
        end else if (!en || realign) begin
            // Idle and realign share one path: counter parked, divisor follows div_val.
            st.cnt     <= '0;
            st.div_act <= DIV_W_MAX'(div_val);
            tick       <= 1'b0;
            clk_out    <= 1'b0;
        end else begin
            clk_out <= (st.cnt < (d >> 1));
            if (st.cnt == last) begin
                st.cnt     <= '0;
                st.div_act <= DIV_W_MAX'(div_val);
                tick       <= 1'b1;
            end else begin
                st.cnt     <= st.cnt + DIV_W_MAX'(1);
                tick       <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock-enable / divided-level generator, NCH independent programmable channels.
// Define CLKDIV_SYNC_EN to add sync_req, which realigns all enabled channels.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned DIV_RST = 1000
) (
    input  logic            clk,
    input  logic            rst,
    clk_div_multi_if.slave  bus
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clk_div_ch #(
            .DIV_W   (DIV_W),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
`ifdef CLKDIV_SYNC_EN
            .sync    (bus.sync_req),
`endif
            .en      (bus.ch_en[i]),
            .div_val (bus.div_val[i*DIV_W +: DIV_W]),
            .tick    (bus.tick[i]),
            .clk_out (bus.clk_out[i]),
            .div_act (bus.div_act[i*DIV_W +: DIV_W])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: expected ticks and sampled levels are queued, a monitor checks them.
module tb_clk_div_multi;

    localparam int unsigned NCH   = 4;
    localparam int unsigned DIV_W = 16;
    localparam int unsigned K_TICK = 0;
    localparam int unsigned K_CLK  = 1;
    localparam int unsigned K_DIV  = 2;

    typedef struct {
        int unsigned at;
        int unsigned kind;
        int unsigned ch;
        int unsigned val;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    int unsigned tq[NCH][$];
    chk_t        chk_q[$];

    clk_div_multi_if #(.NCH(NCH), .DIV_W(DIV_W)) bus ();

    clk_div_multi #(
        .NCH     (NCH),
        .DIV_W   (DIV_W),
        .DIV_RST (1000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void put(input int unsigned at, input int unsigned kind,
                                input int unsigned ch, input int unsigned val);
        chk_t c;
        c.at = at; c.kind = kind; c.ch = ch; c.val = val;
        chk_q.push_back(c);
    endfunction

    function automatic void exp_ticks(input int unsigned ch, input int unsigned first,
                                      input int unsigned period, input int unsigned last);
        for (int unsigned x = first; x <= last; x += period)
            tq[ch].push_back(x);
    endfunction

    task automatic set_div(input int unsigned ch, input int unsigned val);
        bus.div_val[ch*DIV_W +: DIV_W] = val[DIV_W-1:0];
    endtask

    // Monitor: ticks are matched against per-channel queues, levels against timed entries.
    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (bus.tick[i]) begin
                n_chk++;
                if (tq[i].size() == 0) begin
                    n_fail++;
                    $display("FAIL tick_unexpected ch%0d cycle %0d: got tick=1, required 0", i, cyc);
                end else begin
                    int unsigned e;
                    e = tq[i].pop_front();
                    if (e != cyc) begin
                        n_fail++;
                        $display("FAIL tick_time ch%0d: got tick at cycle %0d, required cycle %0d", i, cyc, e);
                    end
                end
            end else if (tq[i].size() != 0 && tq[i][0] < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL tick_missing ch%0d: got no tick by cycle %0d, required at cycle %0d", i, cyc, tq[i][0]);
                void'(tq[i].pop_front());
            end
        end
        for (int k = int'(chk_q.size()) - 1; k >= 0; k--) begin
            if (chk_q[k].at == cyc) begin
                int unsigned act;
                string       nm;
                case (chk_q[k].kind)
                    K_TICK:  begin act = 32'(bus.tick[chk_q[k].ch]);    nm = "tick";    end
                    K_CLK:   begin act = 32'(bus.clk_out[chk_q[k].ch]); nm = "clk_out"; end
                    default: begin act = 32'(bus.div_act[chk_q[k].ch*DIV_W +: DIV_W]); nm = "div_act"; end
                endcase
                n_chk++;
                if (act != chk_q[k].val) begin
                    n_fail++;
                    $display("FAIL %s ch%0d cycle %0d: got %0d, required %0d",
                             nm, chk_q[k].ch, cyc, act, chk_q[k].val);
                end
                chk_q.delete(k);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        int unsigned tr;
        rst         = 1'b1;
        bus.ch_en   = '0;
        bus.div_val = {NCH{16'd7}};
`ifdef CLKDIV_SYNC_EN
        bus.sync_req = 1'b0;
`endif
        // Reset state: divisor input is 7 but reset must force 1000.
        for (int unsigned c = 0; c < NCH; c++) begin
            put(2, K_TICK, c, 0);
            put(2, K_CLK,  c, 0);
            put(2, K_DIV,  c, 1000);
        end
        repeat (2) @(negedge clk);

        // Reset-default divisor of 1000, 500 high / 500 low
        t = cyc;
        rst = 1'b0;
        set_div(0, 1000);
        bus.ch_en[0] = 1'b1;
        exp_ticks(0, t + 1000, 1000, t + 3001);
        put(t + 1,    K_CLK, 0, 1);
        put(t + 500,  K_CLK, 0, 1);
        put(t + 501,  K_CLK, 0, 0);
        put(t + 1000, K_CLK, 0, 0);
        put(t + 1001, K_CLK, 0, 1);
        put(t + 1500, K_CLK, 0, 1);
        put(t + 1501, K_CLK, 0, 0);
        put(t + 1,    K_DIV, 1, 7);
        put(t + 3001, K_CLK, 0, 1);
        put(t + 3002, K_CLK, 0, 0);
        repeat (3001) @(negedge clk);
        bus.ch_en[0] = 1'b0;

        // Odd divisor and clamped 0/1 divisors
        @(negedge clk);
        set_div(1, 3);
        set_div(2, 0);
        set_div(3, 1);
        @(negedge clk);
        t = cyc;
        bus.ch_en[3:1] = 3'b111;
        exp_ticks(1, t + 3, 3, t + 10);
        exp_ticks(2, t + 2, 2, t + 10);
        exp_ticks(3, t + 2, 2, t + 10);
        put(t + 1, K_CLK, 1, 1);
        put(t + 2, K_CLK, 1, 0);
        put(t + 3, K_CLK, 1, 0);
        put(t + 4, K_CLK, 1, 1);
        put(t + 1, K_CLK, 2, 1);
        put(t + 2, K_CLK, 2, 0);
        put(t + 3, K_CLK, 2, 1);
        put(t + 3, K_CLK, 3, 1);
        put(t + 4, K_CLK, 3, 0);
        put(t + 1, K_DIV, 2, 0);
        put(t + 1, K_DIV, 3, 1);
        repeat (10) @(negedge clk);
        bus.ch_en[3:1] = 3'b000;

        // Divisor change 10 -> 4 mid-period takes effect only after terminal count
        @(negedge clk);
        set_div(0, 10);
        @(negedge clk);
        t = cyc;
        bus.ch_en[0] = 1'b1;
        exp_ticks(0, t + 10, 10, t + 10);
        exp_ticks(0, t + 14, 4, t + 22);
        put(t + 5,  K_CLK, 0, 1);
        put(t + 6,  K_CLK, 0, 0);
        put(t + 9,  K_DIV, 0, 10);
        put(t + 10, K_DIV, 0, 4);
        put(t + 12, K_CLK, 0, 1);
        put(t + 13, K_CLK, 0, 0);
        repeat (5) @(negedge clk);
        set_div(0, 4);
        repeat (17) @(negedge clk);
        bus.ch_en[0] = 1'b0;

        // Disable in the terminal cycle suppresses the tick; re-enable restarts a full period
        @(negedge clk);
        set_div(1, 5);
        @(negedge clk);
        t = cyc;
        bus.ch_en[1] = 1'b1;
        exp_ticks(1, t + 5, 5, t + 14);
        put(t + 15, K_TICK, 1, 0);
        put(t + 15, K_CLK,  1, 0);
        repeat (14) @(negedge clk);
        bus.ch_en[1] = 1'b0;
        repeat (3) @(negedge clk);
        tr = cyc;
        bus.ch_en[1] = 1'b1;
        exp_ticks(1, tr + 5, 5, tr + 10);
        put(tr + 1, K_CLK, 1, 1);
        put(tr + 2, K_CLK, 1, 1);
        put(tr + 3, K_CLK, 1, 0);
        repeat (10) @(negedge clk);
        bus.ch_en[1] = 1'b0;

        // Reset mid-period with two channels running
        @(negedge clk);
        set_div(0, 7);
        set_div(1, 5);
        @(negedge clk);
        t = cyc;
        bus.ch_en[1:0] = 2'b11;
        put(t + 3, K_CLK, 0, 1);
        for (int unsigned c = 0; c < NCH; c++) begin
            put(t + 4, K_TICK, c, 0);
            put(t + 4, K_CLK,  c, 0);
            put(t + 4, K_DIV,  c, 1000);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.ch_en = '0;

`ifdef CLKDIV_SYNC_EN
        // Realign ch0 (d=4) and ch1 (d=8) started at skewed phases
        begin
            int unsigned s;
            @(negedge clk);
            set_div(0, 4);
            set_div(1, 8);
            @(negedge clk);
            t = cyc;
            bus.ch_en[0] = 1'b1;
            exp_ticks(0, t + 4, 4, t + 4);
            repeat (3) @(negedge clk);
            bus.ch_en[1] = 1'b1;
            repeat (4) @(negedge clk);
            s = t + 8;
            bus.sync_req = 1'b1;
            exp_ticks(0, s + 4, 4, s + 8);
            exp_ticks(1, s + 8, 8, s + 8);
            put(s,     K_TICK, 0, 0);
            put(s,     K_CLK,  0, 0);
            put(s + 1, K_CLK,  0, 1);
            put(s + 1, K_CLK,  1, 1);
            @(negedge clk);
            bus.sync_req = 1'b0;
            repeat (8) @(negedge clk);
            bus.ch_en = '0;
        end
`endif

        repeat (5) @(negedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            while (tq[i].size() != 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL tick_pending ch%0d: got no tick, required at cycle %0d", i, tq[i][0]);
                void'(tq[i].pop_front());
            end
        end
        while (chk_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL check_pending ch%0d: got no sample, required one at cycle %0d", chk_q[0].ch, chk_q[0].at);
            void'(chk_q.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
